// File: rtl/dprintf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dprintf_pkg
// Brief   : Shared dprintf request widths and request record type.
// Revision: 1.0 - initial release
// ============================================================================
package dprintf_pkg;

   localparam int DPRINTF_ADDR_W = 16;
   localparam int DPRINTF_DATA_W = 64;

   typedef struct packed {
      logic                      valid;
      logic [DPRINTF_ADDR_W-1:0] address;
      logic [DPRINTF_DATA_W-1:0] data_0;
      logic [DPRINTF_DATA_W-1:0] data_1;
      logic [DPRINTF_DATA_W-1:0] data_2;
      logic [DPRINTF_DATA_W-1:0] data_3;
   } t_dprintf_req;

endpackage
`default_nettype wire

// File: rtl/rr_grant_sel.sv
`default_nettype none
// ============================================================================
// Module  : rr_grant_sel
// Brief   : Combinational round-robin selector: first set request at or after i_ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_grant_sel #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [IDX_W-1:0] i_ptr,
   input  logic [N-1:0]     i_req,
   output logic [N-1:0]     o_grant_oh,
   output logic [IDX_W-1:0] o_grant_idx,
   output logic             o_any
);

   logic w_found;

   always_comb begin
      o_grant_oh  = '0;
      o_grant_idx = '0;
      w_found     = 1'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (int'(i_ptr) + k) % N;
         if (!w_found && i_req[j]) begin
            w_found       = 1'b1;
            o_grant_oh[j] = 1'b1;
            o_grant_idx   = IDX_W'(j);
         end
      end
      o_any = w_found;
   end

endmodule
`default_nettype wire

// File: rtl/dprintf_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dprintf_req_arbiter
// Brief   : N-channel round-robin merge of dprintf requests with per-channel hold.
// Revision: 1.0 - initial release
// ============================================================================
module dprintf_req_arbiter
   import dprintf_pkg::*;
#(
   parameter int NUM_CHANNELS  = 4,
   parameter bit PULSE_CAPTURE = 1'b0,
   parameter int CNT_W         = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_CHANNELS-1:0]              req_in__valid,
   input  logic [NUM_CHANNELS*DPRINTF_ADDR_W-1:0] req_in__address,
   input  logic [NUM_CHANNELS*DPRINTF_DATA_W-1:0] req_in__data_0,
   input  logic [NUM_CHANNELS*DPRINTF_DATA_W-1:0] req_in__data_1,
   input  logic [NUM_CHANNELS*DPRINTF_DATA_W-1:0] req_in__data_2,
   input  logic [NUM_CHANNELS*DPRINTF_DATA_W-1:0] req_in__data_3,
   output logic [NUM_CHANNELS-1:0]              req_in__ack,
   output logic                                 req_out__valid,
   output logic [DPRINTF_ADDR_W-1:0]            req_out__address,
   output logic [DPRINTF_DATA_W-1:0]            req_out__data_0,
   output logic [DPRINTF_DATA_W-1:0]            req_out__data_1,
   output logic [DPRINTF_DATA_W-1:0]            req_out__data_2,
   output logic [DPRINTF_DATA_W-1:0]            req_out__data_3,
   input  logic                                 req_out__ack,
   output logic [NUM_CHANNELS*CNT_W-1:0]        drop_count,
   output logic                                 busy
);

   localparam int IDX_W = $clog2(NUM_CHANNELS);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } t_state;

   t_state                  r_state;
   t_state                  w_state_nxt;
   logic [IDX_W-1:0]        r_rr_ptr;
   logic [IDX_W-1:0]        w_ptr_nxt;
   t_dprintf_req            r_out;

   t_dprintf_req            w_hold [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] w_hold_valid;
   logic [NUM_CHANNELS-1:0] w_hold_free;
   logic [NUM_CHANNELS-1:0] w_capture;
   logic [NUM_CHANNELS-1:0] w_grant_oh;
   logic [IDX_W-1:0]        w_grant_idx;
   logic                    w_grant_any;
   logic                    w_grant_fire;

   rr_grant_sel #(
      .N     (NUM_CHANNELS),
      .IDX_W (IDX_W)
   ) u_sel (
      .i_ptr       (r_rr_ptr),
      .i_req       (w_hold_valid),
      .o_grant_oh  (w_grant_oh),
      .o_grant_idx (w_grant_idx),
      .o_any       (w_grant_any)
   );

   for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      t_dprintf_req r_hold;
      logic         r_ack;
      t_dprintf_req w_in;

      assign w_in = {1'b1,
                     req_in__address[gi*DPRINTF_ADDR_W +: DPRINTF_ADDR_W],
                     req_in__data_0[gi*DPRINTF_DATA_W +: DPRINTF_DATA_W],
                     req_in__data_1[gi*DPRINTF_DATA_W +: DPRINTF_DATA_W],
                     req_in__data_2[gi*DPRINTF_DATA_W +: DPRINTF_DATA_W],
                     req_in__data_3[gi*DPRINTF_DATA_W +: DPRINTF_DATA_W]};

      // A handshake source still shows valid during its ack cycle; that is
      // the request just taken, so it must not be captured a second time.
      assign w_hold_free[gi] = !r_hold.valid || (w_grant_fire && w_grant_oh[gi]);
      assign w_capture[gi]   = req_in__valid[gi] && w_hold_free[gi] && (PULSE_CAPTURE || !r_ack);

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_hold <= '0;
            r_ack  <= 1'b0;
         end else begin
            r_ack <= w_capture[gi];
            if (w_capture[gi]) begin
               r_hold <= w_in;
            end else if (w_grant_fire && w_grant_oh[gi]) begin
               r_hold.valid <= 1'b0;
            end
         end
      end

      assign w_hold[gi]       = r_hold;
      assign w_hold_valid[gi] = r_hold.valid;
      assign req_in__ack[gi]  = r_ack;

      if (PULSE_CAPTURE) begin : g_drop
         logic [CNT_W-1:0] r_drop;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_drop <= '0;
            end else if (req_in__valid[gi] && !w_hold_free[gi] && (r_drop != {CNT_W{1'b1}})) begin
               r_drop <= r_drop + 1'b1;
            end
         end

         assign drop_count[gi*CNT_W +: CNT_W] = r_drop;
      end else begin : g_no_drop
         assign drop_count[gi*CNT_W +: CNT_W] = '0;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_fire = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_any) begin
               w_grant_fire = 1'b1;
               w_state_nxt  = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (req_out__ack) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_ptr_nxt = (w_grant_idx == IDX_W'(NUM_CHANNELS-1)) ? '0 : w_grant_idx + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
         r_out    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_fire) begin
            r_out    <= w_hold[w_grant_idx];
            r_rr_ptr <= w_ptr_nxt;
         end else if ((r_state == ST_PRESENT) && req_out__ack) begin
            r_out.valid <= 1'b0;
         end
      end
   end

   assign req_out__valid   = r_out.valid;
   assign req_out__address = r_out.address;
   assign req_out__data_0  = r_out.data_0;
   assign req_out__data_1  = r_out.data_1;
   assign req_out__data_2  = r_out.data_2;
   assign req_out__data_3  = r_out.data_3;
   assign busy             = (|w_hold_valid) || r_out.valid;

endmodule
`default_nettype wire

// File: tb/tb_dprintf_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_dprintf_req_arbiter
// Brief   : Directed vector bench for dprintf_req_arbiter, handshake and pulse builds.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dprintf_req_arbiter;
   import dprintf_pkg::*;

   localparam int N  = 4;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // handshake-mode instance
   logic [N-1:0]    hs_valid, hs_ack;
   logic            hs_ack_out, hs_ovld, hs_busy;
   logic [N*16-1:0] hs_addr;
   logic [N*64-1:0] hs_d0, hs_d1, hs_d2, hs_d3;
   logic [15:0]     hs_oaddr;
   logic [63:0]     hs_od0, hs_od1, hs_od2, hs_od3;
   logic [N*CW-1:0] hs_drop;

   // pulse-mode instance
   logic [N-1:0]    pc_valid, pc_ack;
   logic            pc_ack_out, pc_ovld, pc_busy;
   logic [N*16-1:0] pc_addr;
   logic [N*64-1:0] pc_d0, pc_d1, pc_d2, pc_d3;
   logic [15:0]     pc_oaddr;
   logic [63:0]     pc_od0, pc_od1, pc_od2, pc_od3;
   logic [N*CW-1:0] pc_drop;

   function automatic logic [15:0] ch_addr(input int ch);
      return 16'h0010 + 16'(ch * 32);
   endfunction

   function automatic logic [63:0] ch_data(input int ch, input int k);
      if (ch == 2 && k == 0) return 64'h2020_2087_0000_0011;
      return {16'hDA7A, 8'(k), 8'(ch), 32'h0000_1234 + 32'(ch)};
   endfunction

   for (genvar gi = 0; gi < N; gi++) begin : g_bus
      assign hs_addr[gi*16 +: 16] = ch_addr(gi);
      assign hs_d0[gi*64 +: 64]   = ch_data(gi, 0);
      assign hs_d1[gi*64 +: 64]   = ch_data(gi, 1);
      assign hs_d2[gi*64 +: 64]   = ch_data(gi, 2);
      assign hs_d3[gi*64 +: 64]   = ch_data(gi, 3);
      assign pc_addr[gi*16 +: 16] = ch_addr(gi);
      assign pc_d1[gi*64 +: 64]   = ch_data(gi, 1);
      assign pc_d2[gi*64 +: 64]   = ch_data(gi, 2);
      assign pc_d3[gi*64 +: 64]   = ch_data(gi, 3);
   end

   dprintf_req_arbiter #(.NUM_CHANNELS(N), .PULSE_CAPTURE(1'b0), .CNT_W(CW)) u_hs (
      .clk(clk), .reset(reset),
      .req_in__valid(hs_valid), .req_in__address(hs_addr),
      .req_in__data_0(hs_d0), .req_in__data_1(hs_d1), .req_in__data_2(hs_d2), .req_in__data_3(hs_d3),
      .req_in__ack(hs_ack),
      .req_out__valid(hs_ovld), .req_out__address(hs_oaddr),
      .req_out__data_0(hs_od0), .req_out__data_1(hs_od1), .req_out__data_2(hs_od2), .req_out__data_3(hs_od3),
      .req_out__ack(hs_ack_out), .drop_count(hs_drop), .busy(hs_busy)
   );

   dprintf_req_arbiter #(.NUM_CHANNELS(N), .PULSE_CAPTURE(1'b1), .CNT_W(CW)) u_pc (
      .clk(clk), .reset(reset),
      .req_in__valid(pc_valid), .req_in__address(pc_addr),
      .req_in__data_0(pc_d0), .req_in__data_1(pc_d1), .req_in__data_2(pc_d2), .req_in__data_3(pc_d3),
      .req_in__ack(pc_ack),
      .req_out__valid(pc_ovld), .req_out__address(pc_oaddr),
      .req_out__data_0(pc_od0), .req_out__data_1(pc_od1), .req_out__data_2(pc_od2), .req_out__data_3(pc_od3),
      .req_out__ack(pc_ack_out), .drop_count(pc_drop), .busy(pc_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      hs_valid   = '0;
      hs_ack_out = 1'b0;
      pc_valid   = '0;
      pc_ack_out = 1'b0;
      pc_d0      = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   // One record per cycle: inputs driven in that cycle, registered outputs seen in it.
   typedef struct {
      bit         do_rst;
      logic [3:0] valid;
      logic       ack_out;
      logic [3:0] exp_ack;
      logic       exp_vld;
      int         exp_ch;
      logic       exp_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input bit r, input logic [3:0] v, input logic a,
                               input logic [3:0] ea, input logic ev, input int ch, input logic eb);
      vec_t t;
      t.do_rst = r; t.valid = v; t.ack_out = a;
      t.exp_ack = ea; t.exp_vld = ev; t.exp_ch = ch; t.exp_busy = eb;
      return t;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      hs_valid   = '0;
      hs_ack_out = 1'b0;
      pc_valid   = '0;
      pc_ack_out = 1'b0;
      pc_d0      = '0;

      // single request on ch2, then round-robin with all channels held valid
      tbl.push_back(mk(1, 4'b0100, 1, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 0, 0, 1));
      tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 2, 1));
      tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b1111, 0, 0, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 1, 0, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 0, 0, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 1, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 2, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 3, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 0, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 1));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 1, 1));

      foreach (tbl[i]) begin
         if (tbl[i].do_rst) do_reset();
         hs_valid   = tbl[i].valid;
         hs_ack_out = tbl[i].ack_out;
         chk($sformatf("vec%0d_ack", i), 64'(hs_ack), 64'(tbl[i].exp_ack));
         chk($sformatf("vec%0d_vld", i), 64'(hs_ovld), 64'(tbl[i].exp_vld));
         chk($sformatf("vec%0d_busy", i), 64'(hs_busy), 64'(tbl[i].exp_busy));
         if (tbl[i].exp_vld) begin
            chk($sformatf("vec%0d_addr", i), 64'(hs_oaddr), 64'(ch_addr(tbl[i].exp_ch)));
            chk($sformatf("vec%0d_d0", i), hs_od0, ch_data(tbl[i].exp_ch, 0));
            chk($sformatf("vec%0d_d3", i), hs_od3, ch_data(tbl[i].exp_ch, 3));
         end
         step();
      end

      // stall: ch1 presented with ack_out low for 20 cycles, ch3 waits behind it
      do_reset();
      hs_valid = 4'b0010;
      step();
      chk("stall_ack1", 64'(hs_ack), 64'(4'b0010));
      step();
      hs_valid = 4'b1000;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) step();
         if (k == 1) chk("stall_ack3", 64'(hs_ack), 64'(4'b1000));
         if (k == 2) hs_valid = '0;
         chk($sformatf("stall%0d_vld", k), 64'(hs_ovld), 64'd1);
         chk($sformatf("stall%0d_addr", k), 64'(hs_oaddr), 64'(ch_addr(1)));
         chk($sformatf("stall%0d_d0", k), hs_od0, ch_data(1, 0));
         if (k == 19) hs_ack_out = 1'b1;
      end
      step();
      chk("stall_release_vld", 64'(hs_ovld), 64'd0);
      step();
      chk("stall_next_vld", 64'(hs_ovld), 64'd1);
      chk("stall_next_addr", 64'(hs_oaddr), 64'(ch_addr(3)));
      chk("hs_drop_zero", 64'(hs_drop), 64'd0);

      // pulse mode: ch0 pulses every cycle with downstream stalled
      do_reset();
      for (int k = 0; k < 300; k++) begin
         pc_valid = 4'b0001;
         pc_d0[63:0] = 64'(k);
         if (k == 2) chk("pulse_ack_recap", 64'(pc_ack), 64'(4'b0001));
         if (k == 3) chk("pulse_ack_drop", 64'(pc_ack), 64'(4'b0000));
         if (k == 10) chk("pulse_drop_early", 64'(pc_drop[7:0]), 64'd8);
         step();
      end
      pc_valid = '0;
      chk("pulse_drop_sat", 64'(pc_drop[7:0]), 64'd255);
      chk("pulse_vld", 64'(pc_ovld), 64'd1);
      chk("pulse_first_d0", pc_od0, 64'd0);
      pc_ack_out = 1'b1;
      step();
      chk("pulse_ack_vld", 64'(pc_ovld), 64'd0);
      pc_ack_out = 1'b0;
      step();
      chk("pulse_second_vld", 64'(pc_ovld), 64'd1);
      chk("pulse_second_d0", pc_od0, 64'd1);
      chk("pulse_drop_hold", 64'(pc_drop[7:0]), 64'd255);

      // ch3 granted in the same cycle it pulses a new request
      do_reset();
      pc_valid = 4'b1000;
      pc_d0[192 +: 64] = 64'h33A;
      step();
      pc_d0[192 +: 64] = 64'h33B;
      chk("recap_ack_first", 64'(pc_ack), 64'(4'b1000));
      step();
      pc_valid = '0;
      chk("recap_vld", 64'(pc_ovld), 64'd1);
      chk("recap_d0_old", pc_od0, 64'h33A);
      chk("recap_ack_new", 64'(pc_ack), 64'(4'b1000));
      chk("recap_drop3", 64'(pc_drop[31:24]), 64'd0);
      pc_ack_out = 1'b1;
      step();
      pc_ack_out = 1'b0;
      chk("recap_busy_held", 64'(pc_busy), 64'd1);
      chk("recap_gap_vld", 64'(pc_ovld), 64'd0);
      step();
      chk("recap_new_vld", 64'(pc_ovld), 64'd1);
      chk("recap_d0_new", pc_od0, 64'h33B);
      chk("recap_addr", 64'(pc_oaddr), 64'(ch_addr(3)));
      chk("recap_drop3_end", 64'(pc_drop[31:24]), 64'd0);

      // asynchronous reset while a request is presented and an ack is pulsing
      do_reset();
      hs_valid = 4'b0100;
      pc_valid = 4'b0001;
      step();
      step();
      hs_valid = 4'b0010;
      step();
      chk("rst_pre_vld", 64'(hs_ovld), 64'd1);
      chk("rst_pre_ack", 64'(hs_ack), 64'(4'b0010));
      chk("rst_pre_drop", 64'(pc_drop[7:0]), 64'd1);
      #3;
      reset = 1'b1;
      hs_valid = '0;
      pc_valid = '0;
      hs_ack_out = 1'b1;
      #1;
      chk("rst_async_vld", 64'(hs_ovld), 64'd0);
      chk("rst_async_ack", 64'(hs_ack), 64'd0);
      chk("rst_async_busy", 64'(hs_busy), 64'd0);
      chk("rst_async_drop", 64'(pc_drop), 64'd0);
      chk("rst_async_pc_vld", 64'(pc_ovld), 64'd0);
      step();
      step();
      reset = 1'b0;
      hs_valid = 4'b1001;
      step();
      chk("rst_after_ack", 64'(hs_ack), 64'(4'b1001));
      step();
      hs_valid = '0;
      chk("rst_first_vld", 64'(hs_ovld), 64'd1);
      chk("rst_first_addr", 64'(hs_oaddr), 64'(ch_addr(0)));
      step();
      chk("rst_gap_vld", 64'(hs_ovld), 64'd0);
      step();
      chk("rst_second_addr", 64'(hs_oaddr), 64'(ch_addr(3)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
